// File: rtl/list_walk_engine_if.sv
// Host-side bus of the linked-list walk engine: RAM write port, start/done handshake and result.
interface list_walk_engine_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 8
);
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              start;
   logic [ADDR_W-1:0] head;
   logic [1:0]        mode;
   logic              busy;
   logic              done;
   logic [DATA_W-1:0] result;
   logic [ADDR_W-1:0] count;
   logic              ovf;
   logic              err;

   modport master (
      output wr_en, wr_addr, wr_data, start, head, mode,
      input  busy, done, result, count, ovf, err
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, start, head, mode,
      output busy, done, result, count, ovf, err
   );
endinterface

// File: rtl/list_walk_engine.sv
// Linked-list reduction engine: owns a node RAM, walks a list from a head
// pointer and reduces node values (sum / unsigned max / unsigned min / count).
module list_walk_engine #(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned MAX_NODES = 128
) (
   input logic                clk,
   input logic                rst,
   list_walk_engine_if.slave  bus
);
   typedef enum logic [1:0] {S_IDLE, S_VAL, S_NXT, S_DONE} state_t;

   localparam logic [ADDR_W-1:0] MAX_C = ADDR_W'(MAX_NODES);

   state_t            state_q, state_d;
   logic [1:0]        mode_q, mode_d;
   logic [DATA_W-1:0] acc_q, acc_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              ovf_q, ovf_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic              walk_q, walk_d;
   logic [DATA_W-1:0] res_q, res_d;
   logic [ADDR_W-1:0] rcnt_q, rcnt_d;
   logic              rovf_q, rovf_d;
   logic              rerr_q, rerr_d;

   logic [DATA_W-1:0] mem_q [0:(2**ADDR_W)-1];
   logic [DATA_W-1:0] rd_data_q;
   logic [ADDR_W-1:0] rd_addr;
   logic              mem_we;
   logic [DATA_W:0]   sum_w;
   logic [ADDR_W-1:0] next_w;

   assign sum_w  = {1'b0, acc_q} + {1'b0, rd_data_q};
   assign next_w = rd_data_q[ADDR_W-1:0];

   // Node RAM: single write port, synchronous read with write-first bypass so a
   // launch in the same cycle as a write to the head node sees the new value.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[bus.wr_addr] <= bus.wr_data;
      end
      if (mem_we && (bus.wr_addr == rd_addr)) begin
         rd_data_q <= bus.wr_data;
      end else begin
         rd_data_q <= mem_q[rd_addr];
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         mode_q  <= 2'd0;
         acc_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         ptr_q   <= '0;
         walk_q  <= 1'b0;
         res_q   <= '0;
         rcnt_q  <= '0;
         rovf_q  <= 1'b0;
         rerr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         ptr_q   <= ptr_d;
         walk_q  <= walk_d;
         res_q   <= res_d;
         rcnt_q  <= rcnt_d;
         rovf_q  <= rovf_d;
         rerr_q  <= rerr_d;
      end
   end

   // Next-state logic, read-port address and reduction fold.
   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      ptr_d   = ptr_q;
      walk_d  = walk_q;
      res_d   = res_q;
      rcnt_d  = rcnt_q;
      rovf_d  = rovf_q;
      rerr_d  = rerr_q;
      rd_addr = ptr_q;
      mem_we  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            mem_we = bus.wr_en;
            if (bus.start) begin
               mode_d = bus.mode;
               acc_d  = (bus.mode == 2'd2) ? '1 : '0;
               cnt_d  = '0;
               ovf_d  = 1'b0;
               rcnt_d = '0;
               rovf_d = 1'b0;
               rerr_d = 1'b0;
               if (bus.head != '0) begin
                  ptr_d   = bus.head;
                  rd_addr = bus.head;
                  res_d   = '0;
                  walk_d  = 1'b1;
                  state_d = S_VAL;
               end else begin
                  res_d   = (bus.mode == 2'd2) ? '1 : '0;
                  walk_d  = 1'b0;
                  state_d = S_DONE;
               end
            end
         end
         S_VAL: begin
            cnt_d = cnt_q + ADDR_W'(1);
            unique case (mode_q)
               2'd0: begin
                  acc_d = sum_w[DATA_W-1:0];
                  ovf_d = ovf_q | sum_w[DATA_W];
               end
               2'd1: acc_d = (rd_data_q > acc_q) ? rd_data_q : acc_q;
               2'd2: acc_d = (rd_data_q < acc_q) ? rd_data_q : acc_q;
               default: acc_d = acc_q + DATA_W'(1);
            endcase
            rd_addr = ptr_q + ADDR_W'(1);
            state_d = S_NXT;
         end
         S_NXT: begin
            if ((next_w == '0) || (cnt_q == MAX_C)) begin
               res_d   = acc_q;
               rcnt_d  = cnt_q;
               rovf_d  = ovf_q;
               rerr_d  = (next_w != '0);
               state_d = S_DONE;
            end else begin
               ptr_d   = next_w;
               rd_addr = next_w;
               state_d = S_VAL;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // An empty-list launch passes through DONE without raising busy.
   assign bus.busy   = (state_q != S_IDLE) && walk_q;
   assign bus.done   = (state_q == S_DONE);
   assign bus.result = res_q;
   assign bus.count  = rcnt_q;
   assign bus.ovf    = rovf_q;
   assign bus.err    = rerr_q;
endmodule
